tt_um_and: RTL and testbench
============================

# tt_um_and

Tiny Tapeout user tile computing the bitwise AND of two 8-bit operands, one from the dedicated inputs and one from the bidirectional pins. Both operands are captured in a registered pipeline. The result drives the dedicated outputs. The tile sits directly under the Tiny Tapeout harness wrapper. All bidirectional pins are permanently configured as inputs.

## Interface
Parameters: none. The width is fixed at 8.

Ports:
- clk  in  1  — single system clock; all state on rising edge.
- rst_n  in  1  — reset. Asynchronous, active-high. The harness name is kept.
- ena  in  1  — tile enable. High means the tile is selected and the pipeline advances.
- ui_in  in  8  — operand A.
- uio_in  in  8  — operand B.
- uo_out  out  8  — registered result A & B.
- uio_out  out  8  — tied to 8'h00.
- uio_oe  out  8  — tied to 8'h00, so all uio pins are inputs.
- Gate-level builds only: VPWR and VGND power pins. No function.

## Operation
- Stage 1 (capture): when ena=1, a_q <= ui_in and b_q <= uio_in.
- Stage 2 (compute): when ena=1, r_q <= a_q & b_q.
- uo_out = r_q. The output is purely registered; there is no combinational path from input to output.
- When ena=0: a_q, b_q and r_q all hold their values, and uo_out stays stable.
- Reset (rst_n=1, asynchronous): a_q, b_q and r_q clear to 8'h00 immediately, without waiting for a clock edge.
- Reset beats ena: reset wins over enable.
- Arithmetic: per-bit AND only. There is no carry or cross-bit interaction; bit i of the result depends only on bit i of A and bit i of B.
- uio_out and uio_oe are constant 8'h00 in every state, including during reset.

## Timing
- Latency is 2 enabled clock edges from input to uo_out. Inputs sampled at edge N appear on uo_out after edge N+1.
- Throughput is one result per enabled cycle. There is no handshake.
- Reset values: uo_out=8'h00, uio_out=8'h00, uio_oe=8'h00.
- Reset asserted mid-stream: uo_out goes to 0 asynchronously. After deassertion, the first valid result appears 2 enabled edges after new inputs are sampled.
- Reset deassertion must meet recovery/removal against clk; the harness provides a synchronised release.
- Toggling ena mid-stream: the pipeline freezes, and resumes with no data loss or duplication.

## Structure
- Shared package tt_and_pkg holds these constants:
  - WIDTH = 8
  - RESET_VAL = 8'h00
  - UIO_OE_VAL = 8'h00
- One sub-module: tt_and_core. It contains the two-stage enabled pipeline with async reset, parameterised by WIDTH.
- The top level tt_um_and:
  - instantiates tt_and_core;
  - ties uio_out and uio_oe to the package constants;
  - leaves the power pins unused in RTL.

## Test plan
- Reset: assert rst_n=1 with ui_in=8'hFF and uio_in=8'hFF, no clock edge → uo_out=8'h00, uio_oe=8'h00, uio_out=8'h00.
- Basic AND: release reset, ena=1, ui_in=8'hF0, uio_in=8'h3C → uo_out=8'h30 after 2 edges. At 1 edge uo_out is still 8'h00.
- Streaming: apply (8'hFF,8'hAA), (8'h0F,8'hFF), (8'h55,8'hAA) on consecutive edges → uo_out shows 8'hAA, 8'h0F, 8'h00 on consecutive cycles.
- Enable hold: get uo_out=8'h81 with inputs (8'h81,8'hFF). Then set ena=0 and change inputs to (8'h00,8'h00) for 5 edges → uo_out stays 8'h81. Re-enable → 8'h00 after 2 edges.
- Mid-stream reset: while uo_out=8'hFF, pulse rst_n=1 between clock edges → uo_out=8'h00 immediately, and stays 0 until 2 enabled edges after release.
- Exhaustive per-bit: walking-one on A with B=8'hFF, then walking-one on B with A=8'hFF → each uo_out equals the walked bit; uio_oe is 8'h00 throughout.

Source files
------------

// File: rtl/tt_and_pkg.sv
// Shared constants for the tt_um_and tile: datapath width and the fixed
// values driven onto the reset state and the bidirectional pin controls.
package tt_and_pkg;

  localparam int WIDTH = 8;

  localparam logic [WIDTH-1:0] RESET_VAL  = 8'h00;
  localparam logic [WIDTH-1:0] UIO_OE_VAL = 8'h00;

endpackage : tt_and_pkg

// File: rtl/tt_and_core.sv
// Two-stage enabled pipeline: operands are captured first, then ANDed into a
// result register, so the output never has a combinational path from inputs.
module tt_and_core #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] r_q;

  // Both stages share the enable so a stalled tile freezes without losing data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= RST_VAL;
      b_q <= RST_VAL;
      r_q <= RST_VAL;
    end else if (en) begin
      a_q <= a;
      b_q <= b;
      r_q <= a_q & b_q;
    end
  end

  assign r = r_q;

endmodule : tt_and_core

// File: rtl/tt_um_and.sv
// Tiny Tapeout user tile: registered bitwise AND of ui_in and uio_in on uo_out.
// The uio pins are permanently inputs.
module tt_um_and
  import tt_and_pkg::*;
(
`ifdef USE_POWER_PINS
  inout  wire               VPWR,
  inout  wire               VGND,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [WIDTH-1:0]  ui_in,
  input  logic [WIDTH-1:0]  uio_in,
  output logic [WIDTH-1:0]  uo_out,
  output logic [WIDTH-1:0]  uio_out,
  output logic [WIDTH-1:0]  uio_oe
);

  // rst_n keeps the harness name but is an active-high asynchronous reset.
  tt_and_core #(
    .WIDTH   (WIDTH),
    .RST_VAL (RESET_VAL)
  ) u_core (
    .clk (clk),
    .rst (rst_n),
    .en  (ena),
    .a   (ui_in),
    .b   (uio_in),
    .r   (uo_out)
  );

  assign uio_out = RESET_VAL;
  assign uio_oe  = UIO_OE_VAL;

endmodule : tt_um_and

// File: tb/tb_tt_um_and.sv
// Directed self-checking bench for tt_um_and: reset, latency, streaming,
// enable hold, asynchronous mid-stream reset and walking-one bit isolation.
module tb_tt_um_and;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int total = 0;
  int bad   = 0;

  tt_um_and dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b);
    ui_in  = a;
    uio_in = b;
  endtask

  // Advance one rising edge; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] walk;
    rst_n = 1'b0;
    ena   = 1'b0;
    applyStimulus(8'hFF, 8'hFF);

    // Reset with no clock edge yet
    #2 rst_n = 1'b1;
    #1;
    checkOutput("reset_uo_out", uo_out, 8'h00);
    checkOutput("reset_uio_oe", uio_oe, 8'h00);
    checkOutput("reset_uio_out", uio_out, 8'h00);

    // Reset beats enable across an edge
    ena = 1'b1;
    step();
    checkOutput("reset_beats_ena", uo_out, 8'h00);

    // Basic AND with two-edge latency
    rst_n = 1'b0;
    applyStimulus(8'hF0, 8'h3C);
    step();
    checkOutput("basic_1edge", uo_out, 8'h00);
    step();
    checkOutput("basic_2edge", uo_out, 8'h30);

    // Streaming back-to-back operands
    applyStimulus(8'hFF, 8'hAA);
    step();
    applyStimulus(8'h0F, 8'hFF);
    step();
    checkOutput("stream_0", uo_out, 8'hAA);
    applyStimulus(8'h55, 8'hAA);
    step();
    checkOutput("stream_1", uo_out, 8'h0F);
    step();
    checkOutput("stream_2", uo_out, 8'h00);

    // Enable hold: freeze then resume without loss or duplication
    applyStimulus(8'h81, 8'hFF);
    step();
    step();
    checkOutput("hold_setup", uo_out, 8'h81);
    ena = 1'b0;
    applyStimulus(8'h00, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("hold_%0d", i), uo_out, 8'h81);
    end
    ena = 1'b1;
    step();
    checkOutput("resume_1edge", uo_out, 8'h81);
    step();
    checkOutput("resume_2edge", uo_out, 8'h00);

    // Asynchronous reset pulse between edges
    applyStimulus(8'hFF, 8'hFF);
    step();
    step();
    checkOutput("midrst_pre", uo_out, 8'hFF);
    #2 rst_n = 1'b1;
    #1;
    checkOutput("midrst_async", uo_out, 8'h00);
    #1 rst_n = 1'b0;
    step();
    checkOutput("midrst_1edge", uo_out, 8'h00);
    step();
    checkOutput("midrst_2edge", uo_out, 8'hFF);

    // Walking one on A, then on B
    for (int i = 0; i < 8; i++) begin
      walk = 8'h01 << i;
      applyStimulus(walk, 8'hFF);
      step();
      step();
      checkOutput($sformatf("walk_a_%0d", i), uo_out, walk);
      checkOutput($sformatf("walk_a_oe_%0d", i), uio_oe, 8'h00);
    end
    for (int i = 0; i < 8; i++) begin
      walk = 8'h01 << i;
      applyStimulus(8'hFF, walk);
      step();
      step();
      checkOutput($sformatf("walk_b_%0d", i), uo_out, walk);
      checkOutput($sformatf("walk_b_oe_%0d", i), uio_oe, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_tt_um_and
